// File: rtl/clock_controller.sv
// Front-panel controller for the alarm clock: debounced MODE/SET buttons step a
// seven-state set-mode FSM, issue field increments with auto-repeat, and run the alarm ringer.
module clock_controller #(
    parameter int DEBOUNCE  = 4,
    parameter int REPEAT    = 8,
    parameter int RING_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       tick,
    input  logic       alarm_match,
    output logic [1:0] clock_select,
    output logic       clock_increment,
    output logic [1:0] alarm_select,
    output logic       alarm_increment,
    output logic       alarm_enable,
    output logic       buzzer,
    output logic [2:0] state
);
    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_HOUR = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_SEC  = 2'd3;

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int RP_W = $clog2(REPEAT + 1);
    localparam int RG_W = $clog2(RING_SECS + 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        C_HOUR = 3'd1,
        C_MIN  = 3'd2,
        C_SEC  = 3'd3,
        A_HOUR = 3'd4,
        A_MIN  = 3'd5,
        A_SEC  = 3'd6
    } state_e;

    // Button index 0 is MODE, index 1 is SET.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q, fill_q;
    logic [1:0]      run_q, run_d, acc_q, acc_d, valid_q, valid_d, press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    assign btn_raw = {btn_set, btn_mode};

    // A level is accepted after DEBOUNCE equal samples; a rise only counts as a press
    // once some level has been accepted since reset, so a button held through reset is ignored.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            run_d[i]    = run_q[i];
            acc_d[i]    = acc_q[i];
            valid_d[i]  = valid_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (fill_q[1]) begin
                if (db_cnt_q[i] == '0 || sync2_q[i] != run_q[i]) begin
                    run_d[i]    = sync2_q[i];
                    db_cnt_d[i] = DB_W'(1);
                end else if (db_cnt_q[i] != DB_W'(DEBOUNCE)) begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
                if (db_cnt_d[i] == DB_W'(DEBOUNCE)) begin
                    acc_d[i]   = run_d[i];
                    valid_d[i] = 1'b1;
                end
            end
            press_d[i] = acc_d[i] & ~acc_q[i] & valid_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
            run_q   <= '0;
            acc_q   <= '0;
            valid_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            run_q   <= run_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            press_q <= press_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    state_e          state_q, state_d;
    logic            ring_q, ring_d, match_q;
    logic            enable_q, enable_d;
    logic            clk_inc_q, clk_inc_d, alm_inc_q, alm_inc_d;
    logic            rep_active_q, rep_active_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [RG_W-1:0] ring_cnt_q, ring_cnt_d;
    logic            silence, mode_go, set_go, in_clk, in_alm, fire;

    // Presses that silence the ringer are consumed; MODE wins over a simultaneous SET.
    assign silence = ring_q & (press_q[0] | press_q[1]);
    assign mode_go = press_q[0] & ~ring_q;
    assign set_go  = press_q[1] & ~press_q[0] & ~ring_q;
    assign in_clk  = state_q inside {C_HOUR, C_MIN, C_SEC};
    assign in_alm  = state_q inside {A_HOUR, A_MIN, A_SEC};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mode_go) state_d = (state_q == A_SEC) ? RUN : state_e'(state_q + 3'd1);
    end

    always_comb begin
        clock_select = SELECT_NONE;
        alarm_select = SELECT_NONE;
        case (state_q)
            C_HOUR:  clock_select = SELECT_HOUR;
            C_MIN:   clock_select = SELECT_MIN;
            C_SEC:   clock_select = SELECT_SEC;
            A_HOUR:  alarm_select = SELECT_HOUR;
            A_MIN:   alarm_select = SELECT_MIN;
            A_SEC:   alarm_select = SELECT_SEC;
            default: ;
        endcase
        state = state_q;
    end

    // Any MODE press kills the repeat on the same cycle, so an increment never lands on a new select.
    always_comb begin
        enable_d     = enable_q;
        rep_active_d = rep_active_q;
        rep_cnt_d    = rep_cnt_q;
        ring_d       = ring_q;
        ring_cnt_d   = ring_cnt_q;
        fire         = 1'b0;
        if (set_go && state_q == RUN) enable_d = ~enable_q;
        if (set_go && (in_clk || in_alm)) begin
            fire         = 1'b1;
            rep_active_d = 1'b1;
            rep_cnt_d    = RP_W'(1);
        end else if (rep_active_q) begin
            if (!acc_q[1] || press_q[0]) begin
                rep_active_d = 1'b0;
            end else if (rep_cnt_q >= RP_W'(REPEAT) && !(clk_inc_q || alm_inc_q)) begin
                fire      = 1'b1;
                rep_cnt_d = RP_W'(1);
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_cnt_q + RP_W'(1);
            end
        end
        clk_inc_d = fire & in_clk;
        alm_inc_d = fire & in_alm;
        if (ring_q) begin
            if (silence || !enable_q) begin
                ring_d = 1'b0;
            end else if (tick) begin
                ring_cnt_d = ring_cnt_q + RG_W'(1);
                if (ring_cnt_d == RG_W'(RING_SECS)) ring_d = 1'b0;
            end
        end else if (alarm_match && !match_q && enable_q && state_q == RUN) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q     <= 1'b0;
            rep_active_q <= 1'b0;
            rep_cnt_q    <= '0;
            ring_q       <= 1'b0;
            ring_cnt_q   <= '0;
            match_q      <= 1'b0;
            clk_inc_q    <= 1'b0;
            alm_inc_q    <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            rep_active_q <= rep_active_d;
            rep_cnt_q    <= rep_cnt_d;
            ring_q       <= ring_d;
            ring_cnt_q   <= ring_cnt_d;
            match_q      <= alarm_match;
            clk_inc_q    <= clk_inc_d;
            alm_inc_q    <= alm_inc_d;
        end
    end

    assign clock_increment = clk_inc_q;
    assign alarm_increment = alm_inc_q;
    assign alarm_enable    = enable_q;
    assign buzzer          = ring_q;
endmodule

// File: tb/tb_clock_controller.sv
// Bench for clock_controller: random button holds against a press/hold-length model,
// with a scoreboard of expected increment pulses and direct checks of state and ringer.
module tb_clock_controller;
    localparam int DEBOUNCE  = 4;
    localparam int REPEAT    = 8;
    localparam int RING_SECS = 10;
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_set = 1'b0;
    logic       tick = 1'b0;
    logic       alarm_match = 1'b0;
    logic [1:0] clock_select, alarm_select;
    logic       clock_increment, alarm_increment, alarm_enable, buzzer;
    logic [2:0] state;

    clock_controller #(
        .DEBOUNCE (DEBOUNCE),
        .REPEAT   (REPEAT),
        .RING_SECS(RING_SECS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_mode       (btn_mode),
        .btn_set        (btn_set),
        .tick           (tick),
        .alarm_match    (alarm_match),
        .clock_select   (clock_select),
        .clock_increment(clock_increment),
        .alarm_select   (alarm_select),
        .alarm_increment(alarm_increment),
        .alarm_enable   (alarm_enable),
        .buzzer         (buzzer),
        .state          (state)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         clk_pulses = 0;
    int         alm_pulses = 0;
    logic       sb_bypass = 1'b0;
    logic       prev_inc = 1'b0;
    logic [2:0] exp_q[$];
    int         m_state = 0;
    logic       m_enable = 1'b0;

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Field order within each set group is hour, minute, second.
    function automatic logic [1:0] field_sel(input int st);
        case ((st - 1) % 3)
            0:       return SEL_HOUR;
            1:       return SEL_MIN;
            default: return SEL_SEC;
        endcase
    endfunction

    function automatic logic [1:0] exp_clock_sel(input int st);
        return (st >= 1 && st <= 3) ? field_sel(st) : SEL_NONE;
    endfunction

    function automatic logic [1:0] exp_alarm_sel(input int st);
        return (st >= 4 && st <= 6) ? field_sel(st) : SEL_NONE;
    endfunction

    // Scoreboard monitor: every increment pulse pops one expected {is_alarm, select} entry.
    always @(negedge clk) begin
        if (reset) begin
            if (clock_increment || alarm_increment) begin
                if (clock_increment) clk_pulses++;
                if (alarm_increment) alm_pulses++;
                checks++;
                if (prev_inc) begin
                    failures++;
                    $display("FAIL pulse_gap: got back-to-back increments, expected a low cycle between");
                end
                if (!sb_bypass) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: got clk_inc=%0b alm_inc=%0b, expected no pulse",
                                 clock_increment, alarm_increment);
                    end else begin
                        logic [2:0] exp_e, got_e;
                        exp_e = exp_q.pop_front();
                        got_e = {alarm_increment, alarm_increment ? alarm_select : clock_select};
                        if (got_e !== exp_e || (clock_increment && alarm_increment)) begin
                            failures++;
                            $display("FAIL sb_pulse: got alarm=%0b sel=%0d (both=%0b), expected alarm=%0b sel=%0d",
                                     got_e[2], got_e[1:0], clock_increment && alarm_increment,
                                     exp_e[2], exp_e[1:0]);
                        end
                    end
                end
            end
            prev_inc = clock_increment | alarm_increment;
        end else begin
            prev_inc = 1'b0;
        end
    end

    task automatic press(input int which, input int hold);
        @(posedge clk);
        #1;
        if (which == 0) btn_mode = 1'b1;
        else            btn_set  = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        repeat (DEBOUNCE + 8) @(posedge clk);
    endtask

    task automatic do_mode(input int hold);
        press(0, hold);
        if (hold >= DEBOUNCE) m_state = (m_state + 1) % 7;
        @(negedge clk);
        chk3("state", state, 3'(m_state));
        chk2("clock_select", clock_select, exp_clock_sel(m_state));
        chk2("alarm_select", alarm_select, exp_alarm_sel(m_state));
    endtask

    // A SET held for hold accepted cycles yields one pulse at press, then one per REPEAT while held.
    task automatic do_set(input int hold);
        if (hold >= DEBOUNCE) begin
            if (m_state == 0) m_enable = ~m_enable;
            else begin
                for (int k = 0; k < (hold - 1) / REPEAT + 1; k++)
                    exp_q.push_back({m_state >= 4, field_sel(m_state)});
            end
        end
        press(1, hold);
        @(negedge clk);
        chk_bit("alarm_enable", alarm_enable, m_enable);
    endtask

    task automatic check_reset_outputs(input string name);
        chk3({name, "_state"}, state, 3'd0);
        chk2({name, "_clock_select"}, clock_select, SEL_NONE);
        chk2({name, "_alarm_select"}, alarm_select, SEL_NONE);
        chk_bit({name, "_clock_inc"}, clock_increment, 1'b0);
        chk_bit({name, "_alarm_inc"}, alarm_increment, 1'b0);
        chk_bit({name, "_alarm_enable"}, alarm_enable, 1'b0);
        chk_bit({name, "_buzzer"}, buzzer, 1'b0);
    endtask

    task automatic ring_start(input string name);
        alarm_match = 1'b0;
        repeat (2) @(posedge clk);
        #1 alarm_match = 1'b1;
        @(negedge clk);
        chk_bit({name, "_pre"}, buzzer, 1'b0);
        @(negedge clk);
        chk_bit({name, "_on"}, buzzer, 1'b1);
    endtask

    task automatic give_tick();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, a0, seen;
        logic found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 7; i++) do_mode(DEBOUNCE + 1);

        do_mode(DEBOUNCE + 1);
        do_mode(DEBOUNCE + 2);
        c0 = clk_pulses;
        a0 = alm_pulses;
        do_set(DEBOUNCE + 1 + 3 * REPEAT);
        chk_int("cmin_hold_clk_pulses", clk_pulses - c0, 4);
        chk_int("cmin_hold_alm_pulses", alm_pulses - a0, 0);

        c0 = clk_pulses;
        do_set(DEBOUNCE - 1);
        chk_int("glitch_set_pulses", clk_pulses - c0, 0);
        while (m_state != 0) do_mode(DEBOUNCE + 1);
        do_set(DEBOUNCE - 1);
        chk_bit("glitch_run_enable", alarm_enable, 1'b0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) do_mode($urandom_range(1, DEBOUNCE + 6));
            else                            do_set($urandom_range(1, DEBOUNCE + 4 * REPEAT));
        end

        while (m_state != 0) do_mode(DEBOUNCE + 1);
        if (!m_enable) do_set(DEBOUNCE + 2);
        ring_start("ring1");
        for (int t = 1; t <= RING_SECS; t++) begin
            give_tick();
            @(negedge clk);
            chk_bit($sformatf("ring1_tick%0d", t), buzzer, t < RING_SECS);
        end
        chk_bit("ring1_enable_kept", alarm_enable, 1'b1);

        ring_start("ring2");
        press(0, DEBOUNCE + 2);
        @(negedge clk);
        chk_bit("ring2_mode_silence", buzzer, 1'b0);
        chk3("ring2_state_run", state, 3'd0);
        chk_bit("ring2_enable_kept", alarm_enable, 1'b1);

        ring_start("ring3");
        press(1, DEBOUNCE + 2);
        @(negedge clk);
        chk_bit("ring3_set_silence", buzzer, 1'b0);
        chk_bit("ring3_enable_kept", alarm_enable, 1'b1);

        alarm_match = 1'b0;
        for (int i = 0; i < 4; i++) do_mode(DEBOUNCE + 1);
        @(posedge clk);
        #1 alarm_match = 1'b1;
        repeat (3) @(negedge clk);
        chk_bit("ahour_match_ignored", buzzer, 1'b0);
        for (int i = 0; i < 3; i++) do_mode(DEBOUNCE + 1);
        repeat (3) @(negedge clk);
        chk_bit("match_not_remembered", buzzer, 1'b0);

        ring_start("ring4");
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk_bit("ring4_reset_buzzer", buzzer, 1'b0);
        chk_bit("ring4_reset_enable", alarm_enable, 1'b0);
        alarm_match = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        m_state  = 0;
        m_enable = 1'b0;
        repeat (DEBOUNCE + 10) @(posedge clk);

        do_mode(DEBOUNCE + 1);
        sb_bypass = 1'b1;
        @(posedge clk);
        #1 btn_set = 1'b1;
        found = 1'b0;
        seen  = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (clock_increment) seen++;
            if (seen == 2) found = 1'b1;
        end
        chk_bit("burst_second_pulse_seen", found, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("burst_reset");
        c0 = clk_pulses;
        a0 = alm_pulses;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        m_state  = 0;
        m_enable = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk_int("held_after_reset_clk_pulses", clk_pulses - c0, 0);
        chk_int("held_after_reset_alm_pulses", alm_pulses - a0, 0);
        chk_bit("held_after_reset_enable", alarm_enable, 1'b0);
        chk3("held_after_reset_state", state, 3'd0);
        btn_set = 1'b0;
        repeat (DEBOUNCE + 8) @(posedge clk);
        sb_bypass = 1'b0;
        do_set(DEBOUNCE + 2);

        repeat (30) @(posedge clk);
        chk_int("sb_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
